// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake bundle for the shift-add multiplier.
// master = requester/consumer side, slave = the multiplier.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier (MUL-low) sequencing one combinational ALU.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the shifted multiplier reaches zero.
module alu_mul_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_mul_sequencer_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADD  = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] SHR  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0110;

    logic [2:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             finish;

    alu #(.WIDTH(WIDTH)) u_alu (
        .ctrl (alu_ctrl),
        .a    (alu_a),
        .b    (alu_b),
        .out  (alu_out),
        .zero (alu_zero)
    );

    // IDLE and DONE keep the ALU inputs at zero so the datapath stays quiet.
    always_comb begin
        alu_ctrl = OP_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            ADD: begin
                alu_ctrl = OP_ADD;
                alu_a    = acc;
                alu_b    = mcand;
            end
            SHL: begin
                alu_ctrl = OP_SLL;
                alu_a    = mcand;
                alu_b    = WIDTH'(1);
            end
            SHR: begin
                alu_ctrl = OP_SRL;
                alu_a    = mplier;
                alu_b    = WIDTH'(1);
            end
            default: ;
        endcase
    end

`ifdef MUL_EARLY_EXIT_EN
    // Once the multiplier has shifted down to zero no further ADD can change acc.
    assign finish = (cnt == CNT_W'(WIDTH - 1)) || alu_zero;
`else
    logic unused_zero;
    assign unused_zero = alu_zero;
    assign finish      = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= bus.in_a;
                        mplier <= bus.in_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (mplier[0]) acc <= alu_out;
                    state <= SHL;
                end
                SHL: begin
                    mcand <= alu_out;
                    state <= SHR;
                end
                SHR: begin
                    mplier <= alu_out;
                    if (finish) begin
                        result <= acc;
                        state  <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = result;
endmodule

// Team combinational ALU: 4-bit control, wrap-around arithmetic, Zero flag on the result.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero
);
    localparam int SH_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        out = '0;
        case (ctrl)
            4'b0000: out = a + b;
            4'b0001: out = a - b;
            4'b0010: out = a << shamt;
            4'b0011: out = (a < b) ? WIDTH'(1) : '0;
            4'b0100: out = a ^ b;
            4'b0110: out = a >> shamt;
            4'b0111: out = a | b;
            4'b1000: out = a & b;
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: stimulus pushes expected results, a monitor pops and checks.
module tb_alu_mul_sequencer;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               accept;
        int               lat;
        string            name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cycle = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int hi = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
        return 3 * (hi + 1);
`else
        return 3 * WIDTH;
`endif
    endfunction

    // Present a request at a falling edge and hold it until the accepting rising edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input string name, input bit track);
        bit   ok = 0;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk({name, "_accept"}, 32'(bus.in_ready), 32'd1);
        end else if (track) begin
            e.res    = res;
            e.accept = cycle + 1;
            e.lat    = exp_lat(b);
            e.name   = name;
            q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid && bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL %s_drain: timed out, pending=%0d out_valid=%0b", name, q.size(), bus.out_valid);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_out_valid"},  32'(bus.out_valid),  32'd0);
        chk({name, "_busy"},       32'(bus.busy),       32'd0);
        chk({name, "_in_ready"},   32'(bus.in_ready),   32'd1);
        chk({name, "_out_result"}, 32'(bus.out_result), 32'd0);
    endtask

    // Monitor: new out_valid pops an expectation; held out_valid must keep the same result.
    initial begin : monitor
        logic prev;
        exp_t cur;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (bus.out_valid && !prev) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                    end else begin
                        cur = q.pop_front();
                        chk({cur.name, "_result"},  32'(bus.out_result), 32'(cur.res));
                        chk({cur.name, "_latency"}, 32'(cycle - cur.accept), 32'(cur.lat));
                    end
                end else if (bus.out_valid && prev) begin
                    chk({cur.name, "_hold"}, 32'(bus.out_result), 32'(cur.res));
                end
                prev = bus.out_valid;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic product, busy checked every cycle until the result appears.
        issue(8'd13, 8'd11, 8'h8F, "13x11", 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            chk("busy_during_op", 32'(bus.busy), 32'd1);
            @(negedge clk);
            n++;
        end
        wait_idle("13x11");

        issue(8'd200, 8'd3, 8'h58, "200x3", 1'b1);
        wait_idle("200x3");
        issue(8'hFF, 8'hFF, 8'h01, "255x255", 1'b1);
        wait_idle("255x255");
        issue(8'h00, 8'h55, 8'h00, "0x85", 1'b1);
        wait_idle("0x85");

        // Back-pressure: result held, requests ignored while DONE.
        bus.out_ready = 1'b0;
        issue(8'd5, 8'd6, 8'h1E, "5x6", 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_a     = 8'(i + 40);
            bus.in_b     = 8'(i + 3);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_busy",     32'(bus.busy),     32'd1);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        wait_idle("5x6");

        // Reset in the middle of a 9x9 operation, then a clean request.
        issue(8'd9, 8'd9, 8'h51, "9x9", 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd2, 8'd3, 8'h06, "2x3", 1'b1);
        wait_idle("2x3");

        // in_valid held continuously; only operands at accept edges matter.
        begin
            exp_t e;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = 8'd4;
            bus.in_b     = 8'd4;
            e.res = 8'h10; e.accept = cycle + 1; e.lat = exp_lat(8'd4); e.name = "4x4";
            q.push_back(e);
            @(negedge clk);
            bus.in_a = 8'd9;
            bus.in_b = 8'd9;
            n = 0;
            while (!bus.in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            bus.in_a = 8'd7;
            bus.in_b = 8'd2;
            e.res = 8'h0E; e.accept = cycle + 1; e.lat = exp_lat(8'd2); e.name = "7x2";
            q.push_back(e);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_a     = 8'd11;
            bus.in_b     = 8'd13;
        end
        wait_idle("hold_valid");

        // Early-exit vectors (fixed latency when the feature is disabled).
        issue(8'd7, 8'd1, 8'h07, "7x1", 1'b1);
        wait_idle("7x1");
        issue(8'd3, 8'd0, 8'h00, "3x0", 1'b1);
        wait_idle("3x0");
        issue(8'd3, 8'h80, 8'h80, "3x128", 1'b1);
        wait_idle("3x128");

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
